// File: rtl/opll_bus_pkg.sv
// Shared definitions for the OPLL write sequencer: sequencer state encoding
// and the chip's default bus timing in XIN cycles.
package opll_bus_pkg;

   localparam int unsigned DEF_WR_PULSE  = 4;
   localparam int unsigned DEF_ADDR_WAIT = 12;
   localparam int unsigned DEF_DATA_WAIT = 84;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR_WR   = 3'd1,
      ST_ADDR_WAIT = 3'd2,
      ST_DATA_WR   = 3'd3,
      ST_DATA_WAIT = 3'd4
   } wr_state_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/opll_wr_fifo.sv
// Small synchronous FIFO holding {addr,data} register writes for the OPLL bus.
// Head is read combinationally; the consumer registers it on pop.
module opll_wr_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty,
   output logic             o_full
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;
   assign o_rdata   = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr_ptr] <= i_wdata;
   end

   // Pointers are log2(DEPTH) wide, so natural overflow gives the modulo wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/opll_write_sequencer.sv
// Queues host register writes and replays each one to the OPLL as an address
// strobe then a data strobe, honouring the chip's post-write busy times.
module opll_write_sequencer
   import opll_bus_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WR_PULSE   = DEF_WR_PULSE,
   parameter int unsigned ADDR_WAIT  = DEF_ADDR_WAIT,
   parameter int unsigned DATA_WAIT  = DEF_DATA_WAIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_valid,
   output logic       o_ready,
   input  logic [7:0] i_addr,
   input  logic [7:0] i_data,
   output logic       o_cs_n,
   output logic       o_wr_n,
   output logic       o_a0,
   output logic [7:0] o_d,
   output logic       o_busy
);
   localparam int unsigned CNT_MAX = max3(WR_PULSE, ADDR_WAIT, DATA_WAIT);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] LD_WR = CNT_W'(WR_PULSE - 1);
   localparam logic [CNT_W-1:0] LD_AW = CNT_W'(ADDR_WAIT - 1);
   localparam logic [CNT_W-1:0] LD_DW = CNT_W'(DATA_WAIT - 1);

   wr_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_hold_data;
   logic             r_cs_n;
   logic             r_a0;
   logic [7:0]       r_d;

   logic             w_push;
   logic             w_pop;
   logic             w_empty;
   logic             w_full;
   logic [15:0]      w_head;
   logic             w_cnt_done;

   assign w_push     = i_valid & ~w_full;
   assign w_pop      = (r_state == ST_IDLE) & ~w_empty;
   assign w_cnt_done = (r_cnt == '0);

   opll_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata ({i_addr, i_data}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   // Bus outputs are updated on the same edge as the state they belong to,
   // so each phase lasts exactly its load value + 1 cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_hold_data <= 8'h00;
         r_cs_n      <= 1'b1;
         r_a0        <= 1'b0;
         r_d         <= 8'h00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_hold_data <= w_head[7:0];
                  r_state     <= ST_ADDR_WR;
                  r_cnt       <= LD_WR;
                  r_cs_n      <= 1'b0;
                  r_a0        <= 1'b0;
                  r_d         <= w_head[15:8];
               end
            end
            ST_ADDR_WR: begin
               if (w_cnt_done) begin
                  r_state <= ST_ADDR_WAIT;
                  r_cnt   <= LD_AW;
                  r_cs_n  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_ADDR_WAIT: begin
               if (w_cnt_done) begin
                  r_state <= ST_DATA_WR;
                  r_cnt   <= LD_WR;
                  r_cs_n  <= 1'b0;
                  r_a0    <= 1'b1;
                  r_d     <= r_hold_data;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_DATA_WR: begin
               if (w_cnt_done) begin
                  r_state <= ST_DATA_WAIT;
                  r_cnt   <= LD_DW;
                  r_cs_n  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_DATA_WAIT: begin
               if (w_cnt_done)
                  r_state <= ST_IDLE;
               else
                  r_cnt <= r_cnt - 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_cs_n  <= 1'b1;
            end
         endcase
      end
   end

   // A single register drives both strobes so they can never disagree.
   assign o_cs_n  = r_cs_n;
   assign o_wr_n  = r_cs_n;
   assign o_a0    = r_a0;
   assign o_d     = r_d;
   assign o_ready = ~w_full;
   assign o_busy  = ~w_empty | (r_state != ST_IDLE);

endmodule

// File: tb/tb_opll_write_sequencer.sv
// Directed bench: default-timing instance for single, queued, full and reset
// cases, plus a minimum-timing instance for the shortest bus cycle.
module tb_opll_write_sequencer;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_reset, a_valid, a_ready, a_cs_n, a_wr_n, a_a0, a_busy;
   logic [7:0] a_addr, a_data, a_d;
   logic       b_reset, b_valid, b_ready, b_cs_n, b_wr_n, b_a0, b_busy;
   logic [7:0] b_addr, b_data, b_d;

   int tests = 0;
   int fails = 0;

   logic [7:0] m_addr [8];
   logic [7:0] m_data [8];

   opll_write_sequencer u_dut_a (
      .clk(clk), .reset(a_reset), .i_valid(a_valid), .o_ready(a_ready),
      .i_addr(a_addr), .i_data(a_data), .o_cs_n(a_cs_n), .o_wr_n(a_wr_n),
      .o_a0(a_a0), .o_d(a_d), .o_busy(a_busy)
   );

   opll_write_sequencer #(
      .FIFO_DEPTH(4), .WR_PULSE(1), .ADDR_WAIT(1), .DATA_WAIT(1)
   ) u_dut_b (
      .clk(clk), .reset(b_reset), .i_valid(b_valid), .o_ready(b_ready),
      .i_addr(b_addr), .i_data(b_data), .o_cs_n(b_cs_n), .o_wr_n(b_wr_n),
      .o_a0(b_a0), .o_d(b_d), .o_busy(b_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input int c, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, c, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input int c, input logic [7:0] obs,
                       input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp);
      end
   endtask

   // Default timing: write k is popped in cycle 1+105k; offset o from its pop:
   // 1-4 addr strobe, 5-16 addr wait, 17-20 data strobe, 21-104 data wait.
   task automatic expect_at(input int c, input int n, output logic e_cs,
                            output logic e_a0, output logic [7:0] e_d,
                            output logic e_busy);
      int k;
      int o;
      if (c <= 1) begin
         e_cs = 1'b1; e_a0 = 1'b0; e_d = 8'h00; e_busy = (c == 1);
      end else begin
         k = (c - 2) / 105;
         if (k >= n) k = n - 1;
         o = c - (1 + 105 * k);
         if (o > 105) o = 105;
         e_cs   = !((o >= 1 && o <= 4) || (o >= 17 && o <= 20));
         e_a0   = (o >= 17);
         e_d    = (o <= 16) ? m_addr[k] : m_data[k];
         e_busy = (o < 105) || (k + 1 < n);
      end
   endtask

   task automatic check_a(input string tag, input int c, input int n);
      logic       e_cs, e_a0, e_busy;
      logic [7:0] e_d;
      expect_at(c, n, e_cs, e_a0, e_d, e_busy);
      chk1({tag, "_cs_n"}, c, a_cs_n, e_cs);
      chk1({tag, "_wr_n"}, c, a_wr_n, e_cs);
      chk1({tag, "_a0"},   c, a_a0,   e_a0);
      chk8({tag, "_d"},    c, a_d,    e_d);
      chk1({tag, "_busy"}, c, a_busy, e_busy);
   endtask

   task automatic check_a_reset(input string tag, input int c);
      chk1({tag, "_cs_n"},  c, a_cs_n, 1'b1);
      chk1({tag, "_wr_n"},  c, a_wr_n, 1'b1);
      chk1({tag, "_a0"},    c, a_a0,   1'b0);
      chk8({tag, "_d"},     c, a_d,    8'h00);
      chk1({tag, "_busy"},  c, a_busy, 1'b0);
      chk1({tag, "_ready"}, c, a_ready, 1'b1);
   endtask

   initial begin
      logic [7:0] list_a [6];
      logic [7:0] list_d [6];
      list_a = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
      list_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      a_reset = 1'b1; a_valid = 1'b0; a_addr = 8'h00; a_data = 8'h00;
      b_reset = 1'b1; b_valid = 1'b0; b_addr = 8'h00; b_data = 8'h00;
      #1;
      tick();
      tick();

      // Single write 0x10/0x55.
      a_reset = 1'b0;
      b_reset = 1'b0;
      check_a_reset("rst", 0);
      m_addr[0] = 8'h10; m_data[0] = 8'h55;
      for (int c = 0; c <= 110; c++) begin
         check_a("single", c, 1);
         a_valid = (c == 0);
         a_addr  = 8'h10;
         a_data  = 8'h55;
         tick();
      end
      a_valid = 1'b0;

      // Five accepted (one popped while filling), sixth rejected while full.
      a_reset = 1'b1;
      tick();
      a_reset = 1'b0;
      check_a_reset("rst2", 0);
      for (int i = 0; i < 5; i++) begin
         m_addr[i] = list_a[i];
         m_data[i] = list_d[i];
      end
      for (int c = 0; c <= 540; c++) begin
         check_a("queue", c, 5);
         chk1("queue_ready", c, a_ready, !(c >= 5 && c <= 106));
         a_valid = (c <= 5);
         a_addr  = (c <= 5) ? list_a[c] : 8'h00;
         a_data  = (c <= 5) ? list_d[c] : 8'h00;
         tick();
      end
      a_valid = 1'b0;

      // Reset during the first write's data wait with 3 still queued.
      a_reset = 1'b1;
      tick();
      a_reset = 1'b0;
      for (int c = 0; c <= 50; c++) begin
         if (c <= 1 || c == 2 || c == 18 || c == 50)
            check_a("midrst", c, 4);
         a_valid = (c <= 3);
         a_addr  = (c <= 3) ? list_a[c] : 8'h00;
         a_data  = (c <= 3) ? list_d[c] : 8'h00;
         if (c == 50) a_reset = 1'b1;
         tick();
      end
      a_reset = 1'b0;
      check_a_reset("abort", 51);
      for (int c = 52; c < 352; c++) begin
         chk1("abort_cs_n", c, a_cs_n, 1'b1);
         chk1("abort_busy", c, a_busy, 1'b0);
         tick();
      end

      // Minimum timing instance, write 0xFF/0x00.
      b_valid = 1'b1; b_addr = 8'hFF; b_data = 8'h00;
      chk1("min_ready", 0, b_ready, 1'b1);
      chk1("min_busy",  0, b_busy,  1'b0);
      tick();
      b_valid = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         chk1("min_cs_n", c, b_cs_n, !(c == 2 || c == 4));
         chk1("min_wr_n", c, b_wr_n, !(c == 2 || c == 4));
         chk1("min_busy", c, b_busy, (c <= 5));
         if (c == 2) begin
            chk1("min_a0", c, b_a0, 1'b0);
            chk8("min_d",  c, b_d,  8'hFF);
         end
         if (c == 4) begin
            chk1("min_a0", c, b_a0, 1'b1);
            chk8("min_d",  c, b_d,  8'h00);
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/opll_write_sequencer.md
OPLL_WRITE_SEQUENCER -- requirements
Module: opll_write_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: number of queued (addr,data) writes, power of two, minimum 2.
REQ-002 SHALL have parameter WR_PULSE, default 4: clk cycles CS_n/WR_n are held low per bus write, minimum 1.
REQ-003 SHALL have parameter ADDR_WAIT, default 12: idle clk cycles after the address write, minimum 1.
REQ-004 SHALL have parameter DATA_WAIT, default 84: idle clk cycles after the data write, minimum 1.
REQ-005 clk  input  1  chip master clock (XIN rate), the only clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 i_valid  input  1  host write request.
REQ-008 o_ready  output  1  queue can accept; a push occurs on a cycle with i_valid & o_ready.
REQ-009 i_addr  input  8  OPLL register address.
REQ-010 i_data  input  8  OPLL register data.
REQ-011 o_cs_n  output  1  chip select to OPLL bus, active low.
REQ-012 o_wr_n  output  1  write strobe to OPLL bus, active low.
REQ-013 o_a0  output  1  0 = address port, 1 = data port.
REQ-014 o_d  output  8  OPLL data bus.
REQ-015 o_busy  output  1  high while any write is queued or in flight.

Function
REQ-016 SHALL buffer pushes in a synchronous FIFO; o_ready = not full, computed from the registered count only (a same-cycle pop does not raise o_ready).
REQ-017 SHALL run FSM states IDLE, ADDR_WR, ADDR_WAIT, DATA_WR, DATA_WAIT.
REQ-018 IDLE: if FIFO non-empty, pop the head into a hold register and go to ADDR_WR next cycle; else stay.
REQ-019 ADDR_WR: o_a0=0, o_d=held addr, o_cs_n=o_wr_n=0 for exactly WR_PULSE cycles, then ADDR_WAIT.
REQ-020 ADDR_WAIT: o_cs_n=o_wr_n=1, o_a0/o_d unchanged, for exactly ADDR_WAIT cycles, then DATA_WR.
REQ-021 DATA_WR: o_a0=1, o_d=held data, o_cs_n=o_wr_n=0 for exactly WR_PULSE cycles, then DATA_WAIT.
REQ-022 DATA_WAIT: strobes high, o_a0/o_d unchanged, for exactly DATA_WAIT cycles, then IDLE (always one IDLE cycle between writes).
REQ-023 SHALL use one down-counter sized for max(WR_PULSE,ADDR_WAIT,DATA_WAIT), loaded on each state entry.
REQ-024 All outputs SHALL be registered; o_cs_n and o_wr_n SHALL always be equal.
REQ-025 o_busy = FIFO non-empty OR state != IDLE.
REQ-026 Push while full SHALL be ignored (o_ready low); push and pop in the same cycle SHALL leave count unchanged.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; entry order SHALL be strictly preserved.

Reset
REQ-028 On reset: state=IDLE, FIFO emptied, counter=0, o_cs_n=1, o_wr_n=1, o_a0=0, o_d=0x00, o_busy=0, o_ready=1, effective next cycle.
REQ-029 Reset mid-write SHALL abort the in-flight write with no further strobe; the pending queue is discarded.

Structure
REQ-030 Package opll_bus_pkg SHALL hold the state enum and default timing constants (4, 12, 84).
REQ-031 FIFO SHALL be a sub-module opll_wr_fifo (16-bit entries, parameterised depth); FSM and output registers in the top.

Verification (default parameters; push accepted in cycle 0)
REQ-032 Single write addr 0x10 data 0x55 -> pop cycle 1; strobes low with a0=0,d=0x10 in cycles 2-5; high 6-17; low with a0=1,d=0x55 in 18-21; high 22-105; IDLE and o_busy=0 at cycle 106.
REQ-033 Two back-to-back pushes (0x20/0x11, 0x30/0x22) -> second address strobe in cycles 107-110 with d=0x30; order preserved.
REQ-034 Pushes on cycles 0-4 with i_valid held -> 5 accepted, o_ready=0 from cycle 5, rises the cycle after the next pop (cycle 107).
REQ-035 Reset asserted in cycle 50 (DATA_WAIT) with 3 queued -> cycle 51: strobes high, a0=0, d=0x00, o_busy=0, o_ready=1, no further strobes.
REQ-036 WR_PULSE=1, ADDR_WAIT=1, DATA_WAIT=1, write 0xFF/0x00 -> strobe low cycle 2 only, high cycle 3, low cycle 4 with a0=1, high cycle 5, IDLE cycle 6.
